// File: rtl/comp_sram_if.sv
// comp_sram_if: component-side request/response bundle between arbiter and responder.
interface comp_sram_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int UW = 32,
    parameter int IW = 1
);
    logic          dv;
    logic [AW-1:0] addr;
    logic          write;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          last;
    logic          hld;
    logic          rd_err;
    logic          wr_err;
    logic [DW-1:0] rdata;
    modport master (output dv, addr, write, user, id, wdata, wstrb, last,
                    input hld, rd_err, wr_err, rdata);
    modport slave (input dv, addr, write, user, id, wdata, wstrb, last,
                   output hld, rd_err, wr_err, rdata);
endinterface

// File: rtl/comp_sram_resp.sv
// comp_sram_resp: DEPTH-word memory responder with fixed read latency, range errors and post-reset scrub.
module comp_sram_resp #(
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter int            UW        = 32,
    parameter int            IW        = 1,
    parameter int            DEPTH     = 64,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int            C_LAT     = 1
) (
    input logic       clk,
    input logic       rst,
    comp_sram_if.slave bus
);
    localparam int BC = DW / 8;
    localparam int BW = $clog2(BC);
    localparam int XW = $clog2(DEPTH);
    typedef enum logic {INIT, RUN} state_t;
    state_t        state, state_nx;
    logic [XW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] off, idx_full;
    logic [XW-1:0] idx;
    logic          in_rng, acc;
    logic          pv [C_LAT];
    logic          pe [C_LAT];
    logic [DW-1:0] pd [C_LAT];
    logic          unused_bits;
    assign off      = bus.addr - BASE_ADDR;
    assign idx_full = off >> BW;
    assign idx      = idx_full[XW-1:0];
    assign in_rng   = (bus.addr >= BASE_ADDR) && (idx_full < AW'(DEPTH));
    assign acc      = bus.dv && !bus.hld;
    assign unused_bits = ^{bus.user, bus.id, bus.last, off};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == INIT) ? cnt + XW'(1) : cnt;
        end
    end
    always_comb state_nx = (state == INIT && cnt == XW'(DEPTH - 1)) ? RUN : state;
    assign bus.hld    = (state == INIT);
    assign bus.wr_err = acc && bus.write && !in_rng;
    // Scrub and accepted writes are mutually exclusive since hld covers all of INIT.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[cnt] <= '0;
        else if (!rst && acc && bus.write && in_rng)
            for (int b = 0; b < BC; b++)
                if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
    // Data is captured at acceptance so later writes cannot disturb an in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_LAT; i++) begin
                pv[i] <= 1'b0;
                pe[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= acc && !bus.write;
            pe[0] <= !in_rng;
            pd[0] <= in_rng ? mem[idx] : '0;
            for (int i = 1; i < C_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign bus.rdata  = pv[C_LAT-1] ? pd[C_LAT-1] : '0;
    assign bus.rd_err = pv[C_LAT-1] && pe[C_LAT-1];
endmodule
